// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad sequencer for the 8-bit calculator ALU.
// Collects two-digit BCD operands and an operator, runs the ALU
// for a settle time, then latches result/status for display.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 clear key pulse (same effect as reset)
//   digit_valid, digit  digit key pulse and value (>9 ignored)
//   op_valid, op_sel    operator key pulse: 00 add 01 sub 10 mul 11 div
//   eq_valid            equals key pulse
//   alu_a/b/op          registered ALU operands and opcode
//   alu_result/status   combinational ALU result and carry/ovf/div0
//   disp_value          registered display value
//   result_valid        one-cycle pulse when a result is latched
//   carry_flag          status of the last non-error result
//   error, busy         ERROR state / EXEC or LATCH state
//
// Parameter EXEC_WAIT (1..15): settle cycles before result sampling.
// Macro CALC_CHAIN_EN: an operator key in RESULT chains the previous
// add/sub result (no carry) as operand A of a new calculation.
module calc_sequencer #(
   parameter int unsigned EXEC_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        op_valid,
   input  logic [1:0]  op_sel,
   input  logic        eq_valid,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [1:0]  alu_op,
   input  logic [15:0] alu_result,
   input  logic        alu_status,
   output logic [15:0] disp_value,
   output logic        result_valid,
   output logic        carry_flag,
   output logic        error,
   output logic        busy
);

   typedef enum logic [2:0] {
      ENTER_A,
      ENTER_B,
      EXEC,
      LATCH,
      RESULT,
      ERROR
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(EXEC_WAIT);

   state_t      state, state_n;
   logic [7:0]  a_bcd, a_bcd_n;
   logic [7:0]  b_bcd, b_bcd_n;
   logic [1:0]  op_q, op_q_n;
   logic        b_dig, b_dig_n;
   logic [3:0]  cnt, cnt_n;
   logic [7:0]  alu_a_n, alu_b_n;
   logic [1:0]  alu_op_n;
   logic [15:0] disp_n;
   logic        rv_n, carry_n, error_n, busy_n;

   // Key priority: clr > eq > op > digit; lower keys are dropped.
   logic eq_k, op_k, dig_k;

   assign eq_k  = eq_valid & ~clr;
   assign op_k  = op_valid & ~clr & ~eq_valid;
   assign dig_k = digit_valid & ~clr & ~eq_valid & ~op_valid
                  & (digit <= 4'd9);

   // Two BCD digits to binary: tens*8 + tens*2 + ones.
   function automatic logic [7:0] bcd2bin(input logic [7:0] v);
      logic [7:0] t;
      t = {4'h0, v[7:4]};
      return (t << 3) + (t << 1) + {4'h0, v[3:0]};
   endfunction

   always_comb begin
      state_n  = state;
      a_bcd_n  = a_bcd;
      b_bcd_n  = b_bcd;
      op_q_n   = op_q;
      b_dig_n  = b_dig;
      cnt_n    = cnt;
      alu_a_n  = alu_a;
      alu_b_n  = alu_b;
      alu_op_n = alu_op;
      disp_n   = disp_value;
      carry_n  = carry_flag;
      rv_n     = 1'b0;

      if (clr) begin
         state_n  = ENTER_A;
         a_bcd_n  = 8'h00;
         b_bcd_n  = 8'h00;
         op_q_n   = 2'b00;
         b_dig_n  = 1'b0;
         cnt_n    = 4'd0;
         alu_a_n  = 8'h00;
         alu_b_n  = 8'h00;
         alu_op_n = 2'b00;
         disp_n   = 16'h0000;
         carry_n  = 1'b0;
      end else begin
         unique case (state)
            ENTER_A: begin
               if (op_k) begin
                  op_q_n  = op_sel;
                  b_bcd_n = 8'h00;
                  b_dig_n = 1'b0;
                  disp_n  = 16'h0000;
                  state_n = ENTER_B;
               end else if (dig_k) begin
                  a_bcd_n = {a_bcd[3:0], digit};
                  disp_n  = {8'h00, a_bcd[3:0], digit};
               end
            end
            ENTER_B: begin
               if (eq_k) begin
                  cnt_n    = 4'd0;
                  alu_op_n = op_q;
                  if (op_q[1]) begin
                     alu_a_n = bcd2bin(a_bcd);
                     alu_b_n = bcd2bin(b_bcd);
                  end else begin
                     alu_a_n = a_bcd;
                     alu_b_n = b_bcd;
                  end
                  state_n = EXEC;
               end else if (op_k) begin
                  // Operator can be changed until the first B digit.
                  if (!b_dig) begin
                     op_q_n = op_sel;
                  end
               end else if (dig_k) begin
                  b_bcd_n = {b_bcd[3:0], digit};
                  b_dig_n = 1'b1;
                  disp_n  = {8'h00, b_bcd[3:0], digit};
               end
            end
            EXEC: begin
               // First EXEC cycle applies operands, then EXEC_WAIT
               // settle cycles follow before sampling.
               if (cnt == WAIT_LAST) begin
                  state_n = LATCH;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
            LATCH: begin
               if (op_q == 2'b11 && alu_b == 8'h00) begin
                  disp_n  = 16'hFFFF;
                  state_n = ERROR;
               end else begin
                  disp_n  = alu_result;
                  carry_n = alu_status;
                  rv_n    = 1'b1;
                  state_n = RESULT;
               end
            end
            RESULT: begin
               if (dig_k) begin
                  a_bcd_n = {4'h0, digit};
                  b_bcd_n = 8'h00;
                  b_dig_n = 1'b0;
                  disp_n  = {12'h000, digit};
                  state_n = ENTER_A;
               end
`ifdef CALC_CHAIN_EN
               else if (op_k && !op_q[1] && !carry_flag) begin
                  a_bcd_n = disp_value[7:0];
                  op_q_n  = op_sel;
                  b_bcd_n = 8'h00;
                  b_dig_n = 1'b0;
                  disp_n  = 16'h0000;
                  state_n = ENTER_B;
               end
`endif
            end
            ERROR: begin
               state_n = ERROR;
            end
            default: begin
               state_n = ENTER_A;
            end
         endcase
      end

      busy_n  = (state_n == EXEC) || (state_n == LATCH);
      error_n = (state_n == ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ENTER_A;
         a_bcd        <= 8'h00;
         b_bcd        <= 8'h00;
         op_q         <= 2'b00;
         b_dig        <= 1'b0;
         cnt          <= 4'd0;
         alu_a        <= 8'h00;
         alu_b        <= 8'h00;
         alu_op       <= 2'b00;
         disp_value   <= 16'h0000;
         result_valid <= 1'b0;
         carry_flag   <= 1'b0;
         error        <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         a_bcd        <= a_bcd_n;
         b_bcd        <= b_bcd_n;
         op_q         <= op_q_n;
         b_dig        <= b_dig_n;
         cnt          <= cnt_n;
         alu_a        <= alu_a_n;
         alu_b        <= alu_b_n;
         alu_op       <= alu_op_n;
         disp_value   <= disp_n;
         result_valid <= rv_n;
         carry_flag   <= carry_n;
         error        <= error_n;
         busy         <= busy_n;
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench for calc_sequencer.
// Two instances (EXEC_WAIT 1 and 4) share the key inputs.
module tb_calc_sequencer;

   logic clk = 1'b0;
   logic rst, clr, digit_valid, op_valid, eq_valid;
   logic [3:0] digit;
   logic [1:0] op_sel;

   logic [7:0]  a1, b1, a4, b4;
   logic [1:0]  op1, op4;
   logic [15:0] res1, res4, disp1, disp4;
   logic        st1, st4, rv1, rv4, cf1, cf4;
   logic        err1, err4, busy1, busy4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd8(input int x);
      logic [7:0] v;
      v[7:4] = 4'(x / 10);
      v[3:0] = 4'(x % 10);
      return v;
   endfunction

   // Reference ALU: BCD add/sub, binary mul, div -> {rem, quot}.
   function automatic logic [16:0] alu_f(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [1:0] op);
      int da, db, r;
      logic [16:0] o;
      da = int'(a[7:4]) * 10 + int'(a[3:0]);
      db = int'(b[7:4]) * 10 + int'(b[3:0]);
      o = 17'h0;
      case (op)
         2'b00: begin
            r = da + db;
            o = {(r > 99), 8'h00, bcd8(r % 100)};
         end
         2'b01: begin
            r = da - db;
            if (r < 0) o = {1'b1, 8'h00, bcd8(r + 100)};
            else       o = {1'b0, 8'h00, bcd8(r)};
         end
         2'b10: begin
            r = int'(a) * int'(b);
            o = {(r > 255), 16'(r)};
         end
         default: begin
            if (b == 8'h00) o = {1'b1, 16'h0000};
            else o = {1'b0, 8'(a % b), 8'(a / b)};
         end
      endcase
      return o;
   endfunction

   assign {st1, res1} = alu_f(a1, b1, op1);
   assign {st4, res4} = alu_f(a4, b4, op4);

   calc_sequencer #(.EXEC_WAIT(1)) u1 (
      .clk(clk), .rst(rst), .clr(clr),
      .digit_valid(digit_valid), .digit(digit),
      .op_valid(op_valid), .op_sel(op_sel), .eq_valid(eq_valid),
      .alu_a(a1), .alu_b(b1), .alu_op(op1),
      .alu_result(res1), .alu_status(st1),
      .disp_value(disp1), .result_valid(rv1), .carry_flag(cf1),
      .error(err1), .busy(busy1)
   );

   calc_sequencer #(.EXEC_WAIT(4)) u4 (
      .clk(clk), .rst(rst), .clr(clr),
      .digit_valid(digit_valid), .digit(digit),
      .op_valid(op_valid), .op_sel(op_sel), .eq_valid(eq_valid),
      .alu_a(a4), .alu_b(b4), .alu_op(op4),
      .alu_result(res4), .alu_status(st4),
      .disp_value(disp4), .result_valid(rv4), .carry_flag(cf4),
      .error(err4), .busy(busy4)
   );

   task automatic keys(input logic c, input logic e, input logic o,
                       input logic [1:0] os, input logic dv,
                       input logic [3:0] d);
      @(negedge clk);
      clr = c; eq_valid = e; op_valid = o; op_sel = os;
      digit_valid = dv; digit = d;
      @(posedge clk);
      #1;
      clr = 0; eq_valid = 0; op_valid = 0; digit_valid = 0;
   endtask

   task automatic dig(input logic [3:0] d);
      keys(0, 0, 0, 2'b00, 1, d);
   endtask

   task automatic opk(input logic [1:0] s);
      keys(0, 0, 1, s, 0, 4'h0);
   endtask

   task automatic eqk();
      keys(0, 1, 0, 2'b00, 0, 4'h0);
   endtask

   task automatic clrk();
      keys(1, 0, 0, 2'b00, 0, 4'h0);
   endtask

   // Edges after the eq edge until rv1 is seen (20 = timeout).
   task automatic wait_rv1(output int n);
      n = 0;
      while (rv1 !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      checks++;
      if ({disp1, a1, b1, op1} !== 34'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h %h want 0",
                  disp1, a1, b1, op1);
      end
      checks++;
      if ({rv1, cf1, err1, busy1} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000",
                  {rv1, cf1, err1, busy1});
      end
   endtask

   task automatic test_add();
      int n;
      dig(1); dig(2);
      checks++;
      if (disp1 !== 16'h0012) begin
         errors++;
         $display("FAIL add_disp_a got %h want 0012", disp1);
      end
      opk(2'b00); dig(3); dig(4);
      checks++;
      if (disp1 !== 16'h0034) begin
         errors++;
         $display("FAIL add_disp_b got %h want 0034", disp1);
      end
      eqk();
      checks++;
      if ({a1, b1, op1, busy1} !== {8'h12, 8'h34, 2'b00, 1'b1}) begin
         errors++;
         $display("FAIL add_alu got %h %h %b %b want 12 34 00 1",
                  a1, b1, op1, busy1);
      end
      wait_rv1(n);
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL add_latency got %0d want 3", n);
      end
      checks++;
      if ({disp1, cf1} !== {16'h0046, 1'b0}) begin
         errors++;
         $display("FAIL add_result got %h cf %b want 0046 cf 0",
                  disp1, cf1);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({rv1, busy1} !== 2'b00) begin
         errors++;
         $display("FAIL add_pulse got rv %b busy %b want 0 0",
                  rv1, busy1);
      end
   endtask

   task automatic test_add_carry();
      int n;
      dig(9); dig(9); opk(2'b00); dig(0); dig(1); eqk();
      wait_rv1(n);
      checks++;
      if ({disp1, cf1} !== {16'h0000, 1'b1} || n != 3) begin
         errors++;
         $display("FAIL carry got %h cf %b n %0d want 0000 cf 1 n 3",
                  disp1, cf1, n);
      end
      dig(1); dig(2); dig(3);
      checks++;
      if (disp1 !== 16'h0023) begin
         errors++;
         $display("FAIL shift3 got %h want 0023", disp1);
      end
   endtask

   task automatic test_mul();
      int n;
      clrk();
      dig(1); dig(2); opk(2'b10); dig(2); dig(5); eqk();
      checks++;
      if ({a1, b1, op1} !== {8'd12, 8'd25, 2'b10}) begin
         errors++;
         $display("FAIL mul_conv got %0d %0d %b want 12 25 10",
                  a1, b1, op1);
      end
      wait_rv1(n);
      checks++;
      if ({disp1, cf1} !== {16'h012C, 1'b1}) begin
         errors++;
         $display("FAIL mul_result got %h cf %b want 012C cf 1",
                  disp1, cf1);
      end
   endtask

   task automatic test_div0();
      int pulses;
      pulses = 0;
      dig(7); opk(2'b11); eqk();
      repeat (6) begin
         if (rv1 === 1'b1) pulses++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL div0_pulse got %0d want 0", pulses);
      end
      checks++;
      if ({err1, disp1, cf1} !== {1'b1, 16'hFFFF, 1'b1}) begin
         errors++;
         $display("FAIL div0_err got %b %h cf %b want 1 FFFF cf 1",
                  err1, disp1, cf1);
      end
      dig(5); eqk(); opk(2'b00);
      checks++;
      if ({err1, disp1, busy1} !== {1'b1, 16'hFFFF, 1'b0}) begin
         errors++;
         $display("FAIL err_hold got %b %h %b want 1 FFFF 0",
                  err1, disp1, busy1);
      end
      clrk();
      checks++;
      if ({err1, disp1, cf1} !== {1'b0, 16'h0000, 1'b0}) begin
         errors++;
         $display("FAIL err_clr got %b %h %b want 0 0000 0",
                  err1, disp1, cf1);
      end
   endtask

   task automatic test_div();
      int n;
      dig(5); dig(0); opk(2'b11); dig(7); eqk();
      wait_rv1(n);
      checks++;
      if ({disp1, cf1} !== {16'h0107, 1'b0} || n != 3) begin
         errors++;
         $display("FAIL div got %h cf %b n %0d want 0107 cf 0 n 3",
                  disp1, cf1, n);
      end
   endtask

   task automatic test_latency4();
      int n;
      clrk();
      dig(1); opk(2'b00); dig(2); eqk();
      n = 0;
      while (rv4 !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != 6 || disp4 !== 16'h0003) begin
         errors++;
         $display("FAIL lat4 got n %0d disp %h want 6 0003", n, disp4);
      end
   endtask

   task automatic test_rst_mid_exec();
      int pulses;
      pulses = 0;
      clrk();
      dig(1); dig(5); opk(2'b01); dig(8); eqk();
      @(posedge clk);
      #1;
      checks++;
      if (busy4 !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_busy got %b want 1", busy4);
      end
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      repeat (8) begin
         if (rv4 === 1'b1) pulses++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL rst_pulse got %0d want 0", pulses);
      end
      checks++;
      if ({disp4, a4, b4, op4, cf4, err4, busy4} !== 37'h0) begin
         errors++;
         $display("FAIL rst_state got %h %h %h %b %b %b %b want 0",
                  disp4, a4, b4, op4, cf4, err4, busy4);
      end
   endtask

   task automatic test_priority();
      dig(3); opk(2'b00); dig(5);
      keys(1, 1, 0, 2'b00, 1, 4'd7);
      checks++;
      if ({disp1, busy1, rv1} !== {16'h0000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL prio_clr got %h %b %b want 0000 0 0",
                  disp1, busy1, rv1);
      end
      dig(4); dig(4'd12);
      checks++;
      if (disp1 !== 16'h0044 && disp1 !== 16'h0004) begin
         errors++;
         $display("FAIL prio_enter_a got %h want 0004", disp1);
      end
      checks++;
      if (disp1 !== 16'h0004) begin
         errors++;
         $display("FAIL digit_gt9 got %h want 0004", disp1);
      end
      keys(0, 1, 0, 2'b00, 1, 4'd6);
      checks++;
      if ({disp1, busy1} !== {16'h0004, 1'b0}) begin
         errors++;
         $display("FAIL eq_in_a got %h %b want 0004 0", disp1, busy1);
      end
   endtask

   task automatic test_chain();
      int n;
      clrk();
      dig(1); dig(2); opk(2'b00); dig(3); dig(4); eqk();
      wait_rv1(n);
      opk(2'b00);
`ifdef CALC_CHAIN_EN
      dig(1); eqk();
      wait_rv1(n);
      checks++;
      if (disp1 !== 16'h0047 || n != 3) begin
         errors++;
         $display("FAIL chain got %h n %0d want 0047 n 3", disp1, n);
      end
`else
      checks++;
      if ({disp1, busy1} !== {16'h0046, 1'b0}) begin
         errors++;
         $display("FAIL no_chain got %h %b want 0046 0", disp1, busy1);
      end
`endif
   endtask

   initial begin
      rst = 1; clr = 0; digit_valid = 0; digit = 0;
      op_valid = 0; op_sel = 0; eq_valid = 0;
      test_reset();
      test_add();
      test_add_carry();
      test_mul();
      test_div0();
      test_div();
      test_latency4();
      test_rst_mid_exec();
      test_priority();
      test_chain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Keypad-driven sequencer for the calculator's 8-bit arithmetic unit: add/sub (BCD), mul/div (binary).
- Collects two-digit BCD operands and an operator from debounced key pulses.
- Drives the ALU operand/opcode inputs and holds them stable for a programmable settle time.
- Samples the ALU result and status, then presents the display value and flags.

Parameters:
EXEC_WAIT, 1, cycles the ALU inputs are held stable in EXEC before result is sampled (legal 1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock domain, reset is synchronous and active-high
clr  in  1  single-cycle clear key pulse
digit_valid  in  1  single-cycle digit key pulse
digit  in  4  digit value; values >9 ignored
op_valid  in  1  single-cycle operator key pulse
op_sel  in  2  00=add 01=sub 10=mul 11=div
eq_valid  in  1  single-cycle equals key pulse
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_op  out  2  ALU opcode
alu_result  in  16  ALU result (combinational from alu_a/alu_b/alu_op)
alu_status  in  1  ALU carry/borrow/overflow/div0
disp_value  out  16  registered display value
result_valid  out  1  one-cycle pulse when a result is latched
carry_flag  out  1  latched alu_status of last non-error result
error  out  1  high while in ERROR
busy  out  1  high in EXEC and LATCH

Behaviour:
- All outputs registered. Reset values:
  - alu_a/alu_b/disp_value = 0, alu_op = 00
  - result_valid = carry_flag = error = busy = 0
  - state = ENTER_A, a_bcd = b_bcd = 0, op_q = 00, EXEC counter = 0
- Reset in any state, including mid-EXEC, returns to the reset condition on the next edge; no result pulse.
- Input priority in the same cycle: clr > eq_valid > op_valid > digit_valid; lower ones are dropped.
- clr in any state: same effect as reset except one cycle later is not required. Applies on the same edge.
- Digit entry: operand <= {operand[3:0], digit}.
  - A third digit shifts out the oldest (e.g. 1,2,3 -> 8'h23).
  - digit >9 is ignored.
- State ENTER_A:
  - disp_value = {8'h00, a_bcd}.
  - Digit updates a_bcd.
  - op_valid: op_q <= op_sel, b_bcd <= 0 -> ENTER_B.
  - eq_valid ignored.
- State ENTER_B:
  - disp_value = {8'h00, b_bcd}.
  - op_valid before any B digit replaces op_q; after a B digit it is ignored.
  - eq_valid -> EXEC. B = 00 if no digit was entered.
- Operand conversion on entering EXEC:
  - op_q 00/01: alu_a = a_bcd, alu_b = b_bcd.
  - op_q 10/11: alu_a = 10*tens + ones of a_bcd (binary, 0..99); same for alu_b.
  - alu_op = op_q.
- State EXEC:
  - busy = 1; counter counts EXEC_WAIT cycles with ALU inputs frozen, then -> LATCH.
  - Key inputs except clr are ignored.
- State LATCH (1 cycle): sample alu_result/alu_status.
  - If op_q = 11 and alu_b = 0: -> ERROR, disp_value = 16'hFFFF, error = 1, carry_flag unchanged, no result_valid.
  - Else: disp_value = alu_result, carry_flag = alu_status, result_valid = 1 for one cycle -> RESULT.
- Latency: eq_valid edge to result_valid = EXEC_WAIT + 2 cycles.
- State RESULT:
  - Holds disp_value.
  - Digit: a_bcd <= {4'h0, digit}, b_bcd <= 0 -> ENTER_A.
  - eq_valid ignored.
  - op_valid: see optional feature.
- State ERROR: only clr or rst exit. Digits, op and eq are ignored.
- alu_a/alu_b/alu_op retain their last values outside EXEC/LATCH.

Optional Feature:
- Macro CALC_CHAIN_EN.
- Defined: op_valid in RESULT chains the previous result, when the last op was add/sub and carry_flag = 0.
  - a_bcd <= disp_value[7:0], op_q <= op_sel, b_bcd <= 0 -> ENTER_B.
  - Otherwise op_valid is ignored.
- Not defined: op_valid in RESULT is ignored; a new calculation requires a digit.

Test Plan:
- Keys 1,2,+,3,4,= with EXEC_WAIT = 1 -> alu_a = 8'h12, alu_b = 8'h34, alu_op = 00; result_valid 3 cycles after eq; disp_value = 16'h0046, carry_flag = 0.
- Keys 9,9,+,0,1,= -> disp_value = 16'h0000, carry_flag = 1. Keys 1,2,3 -> disp_value = 16'h0023.
- Keys 1,2,×,2,5,= -> alu_a = 8'd12, alu_b = 8'd25, disp_value = 16'h012C, carry_flag = 1. Keys 5,0,÷,7,= -> disp_value = 16'h0107, carry_flag = 0.
- Keys 7,÷,= -> error = 1, disp_value = 16'hFFFF, no result_valid. Subsequent digit/eq have no effect; clr -> ENTER_A, disp 0, error 0.
- EXEC_WAIT = 4, rst pulsed 2 cycles after eq -> no result_valid; all outputs at reset values. Same cycle clr + eq_valid + digit in ENTER_B -> clr wins.
- CALC_CHAIN_EN defined: 1,2,+,3,4,= then +,1,= -> disp_value = 16'h0047. Without the macro, the + after the result is ignored and disp_value stays 16'h0046.
